// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock/strobe generator with glitch-free reprogramming.
// Each channel divides clk_in by a shadowed divisor/high-time pair applied only at period boundaries.
module clock_divider_mc #(
  parameter int CH    = 4,
  parameter int WIDTH = 16
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       load,
  input  logic [CH*WIDTH-1:0] div_in,
  input  logic [CH*WIDTH-1:0] high_in,
  output logic [CH-1:0]       clk_out,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       pending
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_div_act, r_high_act, r_div_sh, r_high_sh, r_cnt;
    logic             r_pend, r_run, r_clk, r_tick;
    logic [WIDTH-1:0] w_div_in, w_high_in;
    logic [WIDTH-1:0] w_div_nx, w_high_nx, w_cnt_nx;
    logic             w_short, w_last, w_apply;

    assign w_div_in  = div_in[i*WIDTH +: WIDTH];
    assign w_high_in = high_in[i*WIDTH +: WIDTH];

    always_comb begin
      w_short   = (r_div_act < WIDTH'(2));
      w_last    = r_run && !w_short && (r_cnt == r_div_act - WIDTH'(1));
      w_apply   = !r_run || w_short || w_last;
      w_div_nx  = r_div_act;
      w_high_nx = r_high_act;
      if (w_apply && load[i]) begin
        w_div_nx  = w_div_in;
        w_high_nx = w_high_in;
      end else if (w_apply && r_pend) begin
        w_div_nx  = r_div_sh;
        w_high_nx = r_high_sh;
      end
      // Any boundary (idle, strobe cycle, last count) or a strobe-mode divisor restarts at 0.
      if (w_apply || (w_div_nx < WIDTH'(2))) begin
        w_cnt_nx = '0;
      end else begin
        w_cnt_nx = r_cnt + WIDTH'(1);
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_div_act  <= '0;
        r_high_act <= '0;
        r_div_sh   <= '0;
        r_high_sh  <= '0;
        r_cnt      <= '0;
        r_pend     <= 1'b0;
        r_run      <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        if (load[i] && !w_apply) begin
          r_div_sh  <= w_div_in;
          r_high_sh <= w_high_in;
          r_pend    <= 1'b1;
        end else if (w_apply) begin
          r_pend    <= 1'b0;
        end
        r_div_act  <= w_div_nx;
        r_high_act <= w_high_nx;
        if (!en[i]) begin
          r_run  <= 1'b0;
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          // Outputs are registered from next-state values so they line up with the new count.
          r_run  <= 1'b1;
          r_cnt  <= w_cnt_nx;
          r_tick <= (w_cnt_nx == '0);
          r_clk  <= (w_cnt_nx < w_high_nx);
        end
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
    assign pending[i] = r_pend;
  end

endmodule
